dfe_ctrl: RTL and testbench
===========================

DFE_CTRL -- requirements
Module: dfe_ctrl

Interface
REQ-001 SHALL have parameter PULSE_RESPONSE_LENGTH, default 5, number of DFE taps.
REQ-002 SHALL have parameter SIGNAL_RESOLUTION, default 8, sample width in bits; tap word width is SIGNAL_RESOLUTION*4.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 2, cycles held in DRAIN after stop.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, the sole clock.
REQ-005 rstn input 1: asynchronous active-low reset.
REQ-006 cfg_wr_en input 1: tap write strobe.
REQ-007 cfg_addr input $clog2(PULSE_RESPONSE_LENGTH): tap index.
REQ-008 cfg_wr_data input SIGNAL_RESOLUTION*4: upper half is mantissa m, lower half is shift y (tap = m*2^y).
REQ-009 start input 1, stop input 1, clr_err input 1: single-cycle control pulses.
REQ-010 in_valid input 1, in_data input signed SIGNAL_RESOLUTION, in_ready output 1: upstream sample handshake.
REQ-011 dp_valid output 1, dp_data output signed SIGNAL_RESOLUTION: sample stream to the DFE datapath.
REQ-012 tap_bus output PULSE_RESPONSE_LENGTH*SIGNAL_RESOLUTION*4: flattened taps, tap i at bits [(i+1)*W-1 : i*W].
REQ-013 state output 2, taps_loaded output 1, err output 1, sym_count output 16.

Function
REQ-014 FSM states SHALL be IDLE=00, RUN=01, DRAIN=10, ERROR=11, driven on state.
REQ-015 IDLE: cfg_wr_en with cfg_addr < PULSE_RESPONSE_LENGTH SHALL write the tap and set its loaded bit next cycle; cfg_addr >= PULSE_RESPONSE_LENGTH SHALL be ignored.
REQ-016 taps_loaded SHALL be 1 when all loaded bits are set.
REQ-017 IDLE + start: SHALL go to RUN if all taps loaded and tap0 mantissa != 0, else go to ERROR; the check uses register contents before any same-cycle write.
REQ-018 RUN: in_ready SHALL be 1; a transfer (in_valid & in_ready) SHALL produce dp_valid=1, dp_data=in_data exactly 1 cycle later; otherwise dp_valid=0.
REQ-019 RUN: cfg writes SHALL be ignored; tap_bus SHALL remain stable.
REQ-020 RUN + stop: SHALL go to DRAIN; a sample transferred in the same cycle SHALL still be forwarded.
REQ-021 DRAIN: in_ready SHALL be 0; after exactly DRAIN_CYCLES cycles it SHALL return to IDLE; start and stop SHALL be ignored.
REQ-022 ERROR: err SHALL be 1 and in_ready 0; clr_err SHALL return to IDLE next cycle with loaded bits and taps preserved.
REQ-023 start in RUN/DRAIN/ERROR and stop in IDLE/ERROR SHALL be ignored; if start and stop coincide in IDLE, start SHALL take effect.
REQ-024 in_ready SHALL be combinational from state only, never from in_valid.

Reset
REQ-025 rstn low SHALL force state=IDLE, taps=0, loaded bits=0, in_ready=0, dp_valid=0, dp_data=0, err=0, sym_count=0, drain counter=0, asynchronously, including mid-RUN.
REQ-026 The first transfer after reset release SHALL require a full tap load and a start.

Configuration
REQ-027 Macro DFE_CTRL_STATS_EN defined: sym_count SHALL count RUN transfers, saturate at 16'hFFFF, and clear on the IDLE->RUN transition.
REQ-028 Macro DFE_CTRL_STATS_EN undefined: the sym_count port SHALL exist and be tied to 0, with no counter logic.

Structure
REQ-029 Package dfe_ctrl_pkg SHALL hold the state enum, the tap mantissa/shift field width localparams, and the tap word typedef.
REQ-030 Sub-module dfe_tap_regfile SHALL hold the tap registers, loaded bits and write-enable gating; the FSM, handshake, drain counter and statistics SHALL stay in dfe_ctrl.

Verification
REQ-031 Write 5 taps (tap0 = 0x0004_0002), then start -> state=01 next cycle and taps_loaded=1.
REQ-032 Write taps 0-3 only, then start -> state=11 and err=1; then clr_err -> state=00 with tap contents unchanged.
REQ-033 In RUN, send in_data=-28, 28, 84 on consecutive cycles -> dp_data is -28, 28, 84 with dp_valid=1, each 1 cycle later; sym_count=3 when the macro is defined.
REQ-034 stop together with in_valid (in_data=-84) -> dp_data=-84 forwarded, then DRAIN for 2 cycles, then IDLE; in_ready=0 throughout DRAIN.
REQ-035 Deassert rstn mid-RUN -> all outputs at reset values immediately; a following start -> ERROR.
REQ-036 cfg write to addr 6 and a cfg write during RUN -> tap_bus unchanged.

Source files
------------

// File: rtl/dfe_ctrl_pkg.sv
// rtl/dfe_ctrl_pkg.sv - shared types and field widths for the DFE controller
// Purpose: FSM state encoding, tap word field widths and the tap word layout.
// Ports: none (package).
package dfe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_ERROR = 2'b11
  } state_t;

  // Field widths for the default 8-bit sample resolution.
  localparam int SAMPLE_W = 8;
  localparam int MANT_W   = 2 * SAMPLE_W;
  localparam int SHIFT_W  = 2 * SAMPLE_W;
  localparam int TAP_W    = MANT_W + SHIFT_W;

  // Tap value is mant * 2^shift; mantissa occupies the upper half of the word.
  typedef struct packed {
    logic [MANT_W-1:0]  mant;
    logic [SHIFT_W-1:0] shift;
  } tap_word_t;

endpackage

// File: rtl/dfe_ctrl_if.sv
// rtl/dfe_ctrl_if.sv - configuration, control, sample and status bundle for dfe_ctrl
// Purpose: groups every non-clock signal of dfe_ctrl.
// Ports (slave = controller side):
//   inputs : cfg_wr_en, cfg_addr, cfg_wr_data, start, stop, clr_err, in_valid, in_data
//   outputs: in_ready, dp_valid, dp_data, tap_bus, state, taps_loaded, err, sym_count
interface dfe_ctrl_if #(
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int SIGNAL_RESOLUTION     = 8
);
  localparam int AW = (PULSE_RESPONSE_LENGTH > 1) ? $clog2(PULSE_RESPONSE_LENGTH) : 1;
  localparam int TW = SIGNAL_RESOLUTION * 4;

  logic                                   cfg_wr_en;
  logic [AW-1:0]                          cfg_addr;
  logic [TW-1:0]                          cfg_wr_data;
  logic                                   start;
  logic                                   stop;
  logic                                   clr_err;
  logic                                   in_valid;
  logic signed [SIGNAL_RESOLUTION-1:0]    in_data;
  logic                                   in_ready;
  logic                                   dp_valid;
  logic signed [SIGNAL_RESOLUTION-1:0]    dp_data;
  logic [PULSE_RESPONSE_LENGTH*TW-1:0]    tap_bus;
  logic [1:0]                             state;
  logic                                   taps_loaded;
  logic                                   err;
  logic [15:0]                            sym_count;

  modport master (
    output cfg_wr_en, cfg_addr, cfg_wr_data, start, stop, clr_err, in_valid, in_data,
    input  in_ready, dp_valid, dp_data, tap_bus, state, taps_loaded, err, sym_count
  );

  modport slave (
    input  cfg_wr_en, cfg_addr, cfg_wr_data, start, stop, clr_err, in_valid, in_data,
    output in_ready, dp_valid, dp_data, tap_bus, state, taps_loaded, err, sym_count
  );

endinterface

// File: rtl/dfe_tap_regfile.sv
// rtl/dfe_tap_regfile.sv - DFE tap registers with per-tap loaded flags
// Purpose: stores the taps, tracks which have been written, gates writes.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   wr_en, wr_allow      : write strobe and controller permission (IDLE only)
//   wr_addr, wr_data     : tap index and tap word
//   tap_bus              : flattened taps, tap i at [(i+1)*W-1 : i*W]
//   all_loaded           : every tap has been written since reset
//   tap0_mant_nz         : tap 0 mantissa is non-zero
module dfe_tap_regfile
  import dfe_ctrl_pkg::*;
#(
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int SIGNAL_RESOLUTION     = 8
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic                                              wr_en,
  input  logic                                              wr_allow,
  input  logic [((PULSE_RESPONSE_LENGTH > 1) ? $clog2(PULSE_RESPONSE_LENGTH) : 1)-1:0] wr_addr,
  input  logic [SIGNAL_RESOLUTION*4-1:0]                    wr_data,
  output logic [PULSE_RESPONSE_LENGTH*SIGNAL_RESOLUTION*4-1:0] tap_bus,
  output logic                                              all_loaded,
  output logic                                              tap0_mant_nz
);
  localparam int TW = SIGNAL_RESOLUTION * 4;

  logic [PULSE_RESPONSE_LENGTH-1:0][TW-1:0] taps_q;
  logic [PULSE_RESPONSE_LENGTH-1:0]         loaded_q;
  logic                                     addr_ok;
  logic                                     wr_ok;

  // Out-of-range indices are dropped rather than aliased onto a real tap.
  assign addr_ok = (int'(wr_addr) < PULSE_RESPONSE_LENGTH);
  assign wr_ok   = wr_en & wr_allow & addr_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      taps_q   <= '0;
      loaded_q <= '0;
    end else if (wr_ok) begin
      taps_q[wr_addr]   <= wr_data;
      loaded_q[wr_addr] <= 1'b1;
    end
  end

  assign tap_bus      = taps_q;
  assign all_loaded   = &loaded_q;
  assign tap0_mant_nz = |taps_q[0][TW-1 -: TW/2];

endmodule

// File: rtl/dfe_ctrl.sv
// rtl/dfe_ctrl.sv - DFE control FSM, sample handshake and tap configuration
// Purpose: loads taps in IDLE, forwards upstream samples to the DFE datapath
//   with one cycle of latency in RUN, drains for DRAIN_CYCLES after stop and
//   traps bad starts in ERROR until clr_err.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : dfe_ctrl_if slave (config, control pulses, samples, status)
// Optional: DFE_CTRL_STATS_EN enables the saturating RUN transfer counter on
//   sym_count; otherwise sym_count is tied to zero.
module dfe_ctrl
  import dfe_ctrl_pkg::*;
#(
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int DRAIN_CYCLES          = 2
) (
  input  logic       clk,
  input  logic       rstn,
  dfe_ctrl_if.slave  bus
);
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t                              state_q;
  logic                                err_q;
  logic                                dp_valid_q;
  logic signed [SIGNAL_RESOLUTION-1:0] dp_data_q;
  logic [CNT_W-1:0]                    drain_cnt_q;

  logic in_ready;
  logic transfer;
  logic all_loaded;
  logic tap0_mant_nz;
  logic start_ok;

  dfe_tap_regfile #(
    .PULSE_RESPONSE_LENGTH (PULSE_RESPONSE_LENGTH),
    .SIGNAL_RESOLUTION     (SIGNAL_RESOLUTION)
  ) u_regfile (
    .clk          (clk),
    .rstn         (rstn),
    .wr_en        (bus.cfg_wr_en),
    .wr_allow     (state_q == ST_IDLE),
    .wr_addr      (bus.cfg_addr),
    .wr_data      (bus.cfg_wr_data),
    .tap_bus      (bus.tap_bus),
    .all_loaded   (all_loaded),
    .tap0_mant_nz (tap0_mant_nz)
  );

  // Decoded from state alone so upstream never sees a valid->ready loop.
  assign in_ready = (state_q == ST_RUN);
  assign transfer = bus.in_valid & in_ready;
  // Uses registered taps, so a write in the same cycle as start does not count.
  assign start_ok = all_loaded & tap0_mant_nz;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_data_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      dp_valid_q <= transfer;
      if (transfer) dp_data_q <= bus.in_data;
      case (state_q)
        ST_IDLE: begin
          // start wins over a coincident stop; stop alone is meaningless here.
          if (bus.start) begin
            if (start_ok) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        ST_ERROR: begin
          if (bus.clr_err) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.dp_valid    = dp_valid_q;
  assign bus.dp_data     = dp_data_q;
  assign bus.state       = state_q;
  assign bus.taps_loaded = all_loaded;
  assign bus.err         = err_q;

`ifdef DFE_CTRL_STATS_EN
  logic [15:0] sym_count_q;
  logic [15:0] sym_count_d;

  always_comb begin
    sym_count_d = sym_count_q;
    if (state_q == ST_IDLE && bus.start && start_ok) begin
      sym_count_d = '0;
    end else if (transfer && sym_count_q != 16'hFFFF) begin
      sym_count_d = sym_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sym_count_q <= '0;
    else       sym_count_q <= sym_count_d;
  end

  assign bus.sym_count = sym_count_q;
`else
  assign bus.sym_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dfe_ctrl.sv
// tb/tb_dfe_ctrl.sv - self-checking bench for dfe_ctrl
module tb_dfe_ctrl;
  import dfe_ctrl_pkg::*;

  localparam int PRL = 5;
  localparam int SR  = 8;
  localparam int DC  = 2;
  localparam int TW  = SR * 4;
  localparam int AW  = $clog2(PRL);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dfe_ctrl_if #(.PULSE_RESPONSE_LENGTH(PRL), .SIGNAL_RESOLUTION(SR)) bus ();

  dfe_ctrl #(
    .PULSE_RESPONSE_LENGTH (PRL),
    .SIGNAL_RESOLUTION     (SR),
    .DRAIN_CYCLES          (DC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: tap contents, loaded flags, transfer count since RUN entry.
  logic [TW-1:0] tap_m [PRL];
  bit            loaded_m [PRL];
  int            sym_m;

  function automatic logic [PRL*TW-1:0] exp_bus();
    logic [PRL*TW-1:0] v;
    for (int i = 0; i < PRL; i++) v[i*TW +: TW] = tap_m[i];
    return v;
  endfunction

  function automatic logic exp_loaded();
    for (int i = 0; i < PRL; i++) if (!loaded_m[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] exp_sym();
`ifdef DFE_CTRL_STATS_EN
    return (sym_m > 65535) ? 16'hFFFF : 16'(sym_m);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_wr_en = 1'b0; bus.cfg_addr = '0; bus.cfg_wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clr_err = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < PRL; i++) begin tap_m[i] = '0; loaded_m[i] = 1'b0; end
    sym_m = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    model_clear();
    tick();
  endtask

  // Write while the controller is IDLE: in-range addresses update the model.
  task automatic cfg_write_idle(input int addr, input logic [TW-1:0] d);
    bus.cfg_wr_en = 1'b1; bus.cfg_addr = AW'(addr); bus.cfg_wr_data = d;
    tick();
    bus.cfg_wr_en = 1'b0;
    if (addr < PRL) begin tap_m[addr] = d; loaded_m[addr] = 1'b1; end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0b expected 00", bus.state); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", bus.in_ready); end
    checks++; if (bus.dp_valid !== 1'b0) begin errors++; $display("FAIL reset_dp_valid: got %0b expected 0", bus.dp_valid); end
    checks++; if (bus.dp_data !== 8'sd0) begin errors++; $display("FAIL reset_dp_data: got %0h expected 0", bus.dp_data); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", bus.err); end
    checks++; if (bus.sym_count !== 16'h0) begin errors++; $display("FAIL reset_sym_count: got %0h expected 0", bus.sym_count); end
    checks++; if (bus.taps_loaded !== 1'b0) begin errors++; $display("FAIL reset_taps_loaded: got %0b expected 0", bus.taps_loaded); end
    checks++; if (bus.tap_bus !== '0) begin errors++; $display("FAIL reset_tap_bus: got %0h expected 0", bus.tap_bus); end
    rstn = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_load_start();
    logic [PRL*TW-1:0] snap;
    for (int i = 0; i < PRL; i++) begin
      if (i == PRL - 1) begin
        checks++; if (bus.taps_loaded !== 1'b0) begin errors++; $display("FAIL partial_loaded: got %0b expected 0", bus.taps_loaded); end
      end
      cfg_write_idle(i, (i == 0) ? 32'h0004_0002 : TW'($urandom));
    end
    checks++; if (bus.taps_loaded !== exp_loaded()) begin errors++; $display("FAIL full_loaded: got %0b expected %0b", bus.taps_loaded, exp_loaded()); end
    checks++; if (bus.tap_bus !== exp_bus()) begin errors++; $display("FAIL tap_bus_load: got %0h expected %0h", bus.tap_bus, exp_bus()); end
    // Out-of-range addresses must not disturb any tap.
    snap = exp_bus();
    cfg_write_idle(6, TW'($urandom));
    cfg_write_idle(5, TW'($urandom));
    cfg_write_idle(7, TW'($urandom));
    checks++; if (bus.tap_bus !== snap) begin errors++; $display("FAIL tap_bus_oob_write: got %0h expected %0h", bus.tap_bus, snap); end
    // start and stop together in IDLE: start wins.
    bus.stop = 1'b1;
    pulse_start();
    bus.stop = 1'b0;
    sym_m = 0;
    checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL start_to_run: got %0b expected 01", bus.state); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready: got %0b expected 1", bus.in_ready); end
    checks++; if (bus.taps_loaded !== 1'b1) begin errors++; $display("FAIL run_taps_loaded: got %0b expected 1", bus.taps_loaded); end
  endtask

  // Each cycle's transfer must appear on dp_* exactly one edge later.
  task automatic test_run_stream(input int n_random);
    logic signed [SR-1:0] fixed [3];
    logic signed [SR-1:0] d;
    logic [PRL*TW-1:0]    snap;
    bit                   v;
    fixed[0] = SR'(-28); fixed[1] = SR'(28); fixed[2] = SR'(84);
    snap = exp_bus();
    for (int k = 0; k < 3 + n_random; k++) begin
      if (k < 3) begin v = 1'b1; d = fixed[k]; end
      else begin v = 1'($urandom_range(0, 1)); d = SR'($urandom); end
      bus.in_valid = v; bus.in_data = d;
      // Noise that RUN must ignore: config writes, start, clr_err.
      bus.cfg_wr_en   = (k >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.cfg_addr    = AW'($urandom_range(0, PRL - 1));
      bus.cfg_wr_data = TW'($urandom);
      bus.start       = (k >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.clr_err     = (k >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (v) sym_m++;
      checks++; if (bus.dp_valid !== v) begin errors++; $display("FAIL stream_dp_valid[%0d]: got %0b expected %0b", k, bus.dp_valid, v); end
      if (v) begin
        checks++; if (bus.dp_data !== d) begin errors++; $display("FAIL stream_dp_data[%0d]: got %0d expected %0d", k, bus.dp_data, d); end
      end
      checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL stream_state[%0d]: got %0b expected 01", k, bus.state); end
      checks++; if (bus.tap_bus !== snap) begin errors++; $display("FAIL stream_tap_bus[%0d]: got %0h expected %0h", k, bus.tap_bus, snap); end
      if (k == 2) begin
        checks++; if (bus.sym_count !== exp_sym()) begin errors++; $display("FAIL sym_count_three: got %0d expected %0d", bus.sym_count, exp_sym()); end
      end
    end
    idle_inputs();
    checks++; if (bus.sym_count !== exp_sym()) begin errors++; $display("FAIL sym_count_stream: got %0d expected %0d", bus.sym_count, exp_sym()); end
  endtask

  task automatic test_stop_drain();
    int drain_seen;
    bus.in_valid = 1'b1; bus.in_data = SR'(-84); bus.stop = 1'b1;
    tick();
    sym_m++;
    checks++; if (bus.dp_valid !== 1'b1) begin errors++; $display("FAIL stop_dp_valid: got %0b expected 1", bus.dp_valid); end
    checks++; if (bus.dp_data !== SR'(-84)) begin errors++; $display("FAIL stop_dp_data: got %0d expected -84", bus.dp_data); end
    drain_seen = 0;
    // start/stop/in_valid held high through DRAIN must change nothing.
    bus.start = 1'b1;
    for (int c = 0; c < DC + 3 && bus.state == 2'b10; c++) begin
      drain_seen++;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready[%0d]: got %0b expected 0", c, bus.in_ready); end
      tick();
      checks++; if (bus.dp_valid !== 1'b0) begin errors++; $display("FAIL drain_dp_valid[%0d]: got %0b expected 0", c, bus.dp_valid); end
    end
    idle_inputs();
    checks++; if (drain_seen !== DC) begin errors++; $display("FAIL drain_length: got %0d expected %0d", drain_seen, DC); end
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL drain_to_idle: got %0b expected 00", bus.state); end
    checks++; if (bus.sym_count !== exp_sym()) begin errors++; $display("FAIL sym_count_after_drain: got %0d expected %0d", bus.sym_count, exp_sym()); end
  endtask

  task automatic test_error_clr();
    tap_word_t tw;
    do_reset();
    for (int i = 0; i < PRL - 1; i++) cfg_write_idle(i, TW'($urandom) | 32'h0001_0000);
    pulse_start();
    checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL partial_start_state: got %0b expected 11", bus.state); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL partial_start_err: got %0b expected 1", bus.err); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL error_in_ready: got %0b expected 0", bus.in_ready); end
    bus.start = 1'b1; bus.stop = 1'b1; bus.in_valid = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL error_sticky: got %0b expected 11", bus.state); end
    bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL clr_err_state: got %0b expected 00", bus.state); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL clr_err_err: got %0b expected 0", bus.err); end
    checks++; if (bus.tap_bus !== exp_bus()) begin errors++; $display("FAIL clr_err_taps: got %0h expected %0h", bus.tap_bus, exp_bus()); end
    // Loaded flags survive ERROR: one more write completes the set.
    cfg_write_idle(PRL - 1, TW'($urandom));
    checks++; if (bus.taps_loaded !== 1'b1) begin errors++; $display("FAIL loaded_preserved: got %0b expected 1", bus.taps_loaded); end
    // All loaded but tap0 mantissa zero must also fault.
    tw.mant = '0; tw.shift = SHIFT_W'($urandom);
    cfg_write_idle(0, tw);
    pulse_start();
    checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL zero_mant_state: got %0b expected 11", bus.state); end
    bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
    tw.mant = MANT_W'($urandom_range(1, 65535)); tw.shift = SHIFT_W'($urandom);
    cfg_write_idle(0, tw);
    pulse_start();
    sym_m = 0;
    checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL restart_run: got %0b expected 01", bus.state); end
  endtask

  task automatic test_reset_mid_run();
    bus.in_valid = 1'b1; bus.in_data = SR'($urandom_range(1, 100));
    tick();
    idle_inputs();
    #2;
    rstn = 1'b0;
    #1;
    model_clear();
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL midrun_state: got %0b expected 00", bus.state); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrun_in_ready: got %0b expected 0", bus.in_ready); end
    checks++; if (bus.dp_valid !== 1'b0) begin errors++; $display("FAIL midrun_dp_valid: got %0b expected 0", bus.dp_valid); end
    checks++; if (bus.dp_data !== 8'sd0) begin errors++; $display("FAIL midrun_dp_data: got %0d expected 0", bus.dp_data); end
    checks++; if (bus.tap_bus !== exp_bus()) begin errors++; $display("FAIL midrun_tap_bus: got %0h expected 0", bus.tap_bus); end
    checks++; if (bus.taps_loaded !== 1'b0) begin errors++; $display("FAIL midrun_taps_loaded: got %0b expected 0", bus.taps_loaded); end
    checks++; if (bus.sym_count !== 16'h0) begin errors++; $display("FAIL midrun_sym_count: got %0h expected 0", bus.sym_count); end
    tick();
    rstn = 1'b1;
    tick();
    pulse_start();
    checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL post_reset_start: got %0b expected 11", bus.state); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL post_reset_err: got %0b expected 1", bus.err); end
  endtask

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_load_start();
    test_run_stream(40);
    test_stop_drain();
    test_error_clr();
    test_run_stream(10);
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
